// File: rtl/traffic_pkg.sv
// Shared types and lamp-decoding helpers for the intersection environment model.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_UNK = 2'd0,
    PH_G   = 2'd1,
    PH_Y   = 2'd2,
    PH_R   = 2'd3
  } light_phase_e;

  // Map a street's three lamps to its phase; anything not one-hot is PH_UNK.
  function automatic light_phase_e lamps_to_phase(input logic r, input logic y, input logic g);
    light_phase_e ph;
    case ({r, y, g})
      3'b100:  ph = PH_R;
      3'b010:  ph = PH_Y;
      3'b001:  ph = PH_G;
      default: ph = PH_UNK;
    endcase
    return ph;
  endfunction

  // Legal moves: hold, G->Y, Y->R, R->G; an unknown history accepts anything.
  function automatic logic is_legal_transition(input light_phase_e from_ph, input light_phase_e to_ph);
    logic ok;
    ok = (from_ph == PH_UNK) || (from_ph == to_ph) ||
         (from_ph == PH_G && to_ph == PH_Y) ||
         (from_ph == PH_Y && to_ph == PH_R) ||
         (from_ph == PH_R && to_ph == PH_G);
    return ok;
  endfunction

endpackage

// File: rtl/street_queue.sv
// Car queue for one street: arrivals add cars, a green-time timer releases them.
module street_queue
  import traffic_pkg::*;
#(
  parameter int Q_W           = 4,
  parameter int DEPART_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           green,
  input  logic           arr,
  output logic [Q_W-1:0] q,
  output logic           ovf
);

  localparam int             T_W    = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(DEPART_CYCLES - 1);
  localparam logic [Q_W-1:0] Q_MAX  = '1;

  logic [T_W-1:0] timer;
  logic           at_limit;
  logic           depart;

  // A car leaves only once the timer has accumulated enough green and someone is waiting.
  always_comb begin
    at_limit = (timer == T_LAST);
    depart   = green && at_limit && (q != '0);
  end

  // Timer, occupancy and overflow flag; arrival and departure in one cycle cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      q     <= '0;
      ovf   <= 1'b0;
    end else begin
      if (!green) begin
        timer <= '0;
      end else if (at_limit) begin
        // Empty queue parks the timer at its limit so a new car leaves promptly.
        if (q != '0) timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (arr && !depart) begin
        if (q == Q_MAX) ovf <= 1'b1;
        else            q   <= q + 1'b1;
      end else if (depart && !arr) begin
        q <= q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_traffic_model.sv
// Environment model of a two-street intersection: car queues driving TA/TB and
// a monitor that flags illegal lamp patterns and phase sequences.
module intersection_traffic_model
  import traffic_pkg::*;
#(
  parameter int Q_W           = 4,
  parameter int DEPART_CYCLES = 2,
  parameter int ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RA,
  input  logic                YA,
  input  logic                GA,
  input  logic                RB,
  input  logic                YB,
  input  logic                GB,
  input  logic                arr_a,
  input  logic                arr_b,
  output logic                TA,
  output logic                TB,
  output logic [Q_W-1:0]      qa,
  output logic [Q_W-1:0]      qb,
  output logic                ovf_a,
  output logic                ovf_b,
  output logic                err_onehot,
  output logic                err_conflict,
  output logic                err_seq,
  output logic [ERRCNT_W-1:0] err_cnt
);

  light_phase_e ph_a, ph_b;
  light_phase_e smp_a, smp_b;
  logic         bad_oh_a, bad_oh_b;
  logic         bad_seq_a, bad_seq_b;
  logic         bad_conflict;
  logic         any_viol;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  street_queue #(.Q_W(Q_W), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_a (
    .clk   (clk),
    .rst   (rst),
    .green (GA),
    .arr   (arr_a),
    .q     (qa),
    .ovf   (ovf_a)
  );

  street_queue #(.Q_W(Q_W), .DEPART_CYCLES(DEPART_CYCLES)) u_queue_b (
    .clk   (clk),
    .rst   (rst),
    .green (GB),
    .arr   (arr_b),
    .q     (qb),
    .ovf   (ovf_b)
  );

  assign TA = (qa != '0);
  assign TB = (qb != '0);

  // Classify this cycle's lamps; sequence checks only apply to a valid sampled phase.
  always_comb begin
    smp_a        = lamps_to_phase(RA, YA, GA);
    smp_b        = lamps_to_phase(RB, YB, GB);
    bad_oh_a     = (smp_a == PH_UNK);
    bad_oh_b     = (smp_b == PH_UNK);
    bad_seq_a    = !bad_oh_a && !is_legal_transition(ph_a, smp_a);
    bad_seq_b    = !bad_oh_b && !is_legal_transition(ph_b, smp_b);
    bad_conflict = !RA && !RB;
    any_viol     = bad_oh_a || bad_oh_b || bad_seq_a || bad_seq_b || bad_conflict;
  end

  // Phase history, sticky error flags and the once-per-cycle saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_a         <= PH_UNK;
      ph_b         <= PH_UNK;
      err_onehot   <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      // A malformed pattern leaves the last good phase in place.
      if (!bad_oh_a) ph_a <= smp_a;
      if (!bad_oh_b) ph_b <= smp_b;
      if (bad_oh_a || bad_oh_b)   err_onehot   <= 1'b1;
      if (bad_seq_a || bad_seq_b) err_seq      <= 1'b1;
      if (bad_conflict)           err_conflict <= 1'b1;
      if (any_viol)               err_cnt      <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed bench for intersection_traffic_model with a behavioural reference model.
module tb_intersection_traffic_model;

  localparam int Q_W  = 4;
  localparam int DC   = 2;
  localparam int EW   = 8;
  localparam int QMAX = 15;
  localparam int CMAX = 255;

  localparam logic [2:0] LR  = 3'b100;
  localparam logic [2:0] LY  = 3'b010;
  localparam logic [2:0] LG  = 3'b001;
  localparam logic [2:0] LRY = 3'b110;
  localparam logic [2:0] LYG = 3'b011;

  logic          clk = 1'b0;
  logic          rst;
  logic          RA, YA, GA, RB, YB, GB;
  logic          arr_a, arr_b;
  logic          TA, TB;
  logic [Q_W-1:0] qa, qb;
  logic          ovf_a, ovf_b;
  logic          err_onehot, err_conflict, err_seq;
  logic [EW-1:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int  mq[2];
  int  mt[2];
  bit  movf[2];
  byte mph[2];
  bit  m_oh, m_cf, m_sq;
  int  mcnt;

  intersection_traffic_model #(.Q_W(Q_W), .DEPART_CYCLES(DC), .ERRCNT_W(EW)) dut (
    .clk          (clk),
    .rst          (rst),
    .RA           (RA),
    .YA           (YA),
    .GA           (GA),
    .RB           (RB),
    .YB           (YB),
    .GB           (GB),
    .arr_a        (arr_a),
    .arr_b        (arr_b),
    .TA           (TA),
    .TB           (TB),
    .qa           (qa),
    .qb           (qb),
    .ovf_a        (ovf_a),
    .ovf_b        (ovf_b),
    .err_onehot   (err_onehot),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit legal(input byte f, input byte t);
    return (f == "U") || (f == t) || (f == "G" && t == "Y") ||
           (f == "Y" && t == "R") || (f == "R" && t == "G");
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit  g[2], a[2], lr[2], ly[2], lg[2];
    bit  dep, v_oh, v_sq, v_cf;
    byte p;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        mq[s] = 0; mt[s] = 0; movf[s] = 0; mph[s] = "U";
      end
      m_oh = 0; m_cf = 0; m_sq = 0; mcnt = 0;
      return;
    end
    g[0] = GA; g[1] = GB; a[0] = arr_a; a[1] = arr_b;
    lr[0] = RA; ly[0] = YA; lg[0] = GA;
    lr[1] = RB; ly[1] = YB; lg[1] = GB;
    v_oh = 0; v_sq = 0; v_cf = 0;
    for (int s = 0; s < 2; s++) begin
      dep = 0;
      if (!g[s]) mt[s] = 0;
      else if (mt[s] == DC - 1) begin
        if (mq[s] > 0) begin dep = 1; mt[s] = 0; end
      end else mt[s] = mt[s] + 1;
      if (a[s] && !dep) begin
        if (mq[s] == QMAX) movf[s] = 1; else mq[s] = mq[s] + 1;
      end else if (dep && !a[s]) mq[s] = mq[s] - 1;
      if (int'(lr[s]) + int'(ly[s]) + int'(lg[s]) != 1) v_oh = 1;
      else begin
        p = lr[s] ? "R" : (ly[s] ? "Y" : "G");
        if (!legal(mph[s], p)) v_sq = 1;
        mph[s] = p;
      end
    end
    if (!RA && !RB) v_cf = 1;
    if (v_oh) m_oh = 1;
    if (v_sq) m_sq = 1;
    if (v_cf) m_cf = 1;
    if ((v_oh || v_sq || v_cf) && mcnt < CMAX) mcnt = mcnt + 1;
  endtask

  task automatic check_all();
    check("qa", 32'(qa), mq[0]);
    check("qb", 32'(qb), mq[1]);
    check("TA", 32'(TA), int'(mq[0] != 0));
    check("TB", 32'(TB), int'(mq[1] != 0));
    check("ovf_a", 32'(ovf_a), int'(movf[0]));
    check("ovf_b", 32'(ovf_b), int'(movf[1]));
    check("err_onehot", 32'(err_onehot), int'(m_oh));
    check("err_conflict", 32'(err_conflict), int'(m_cf));
    check("err_seq", 32'(err_seq), int'(m_sq));
    check("err_cnt", 32'(err_cnt), mcnt);
  endtask

  // Apply one cycle of inputs, update the model at the edge, compare on the falling edge.
  task automatic cyc(input bit r, input logic [2:0] la, input logic [2:0] lb,
                     input bit aa, input bit ab);
    rst = r;
    {RA, YA, GA} = la;
    {RB, YB, GB} = lb;
    arr_a = aa;
    arr_b = ab;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int exp_qa[6];
    int guard;
    exp_qa = '{3, 2, 2, 1, 1, 0};
    mq[0] = 0; mq[1] = 0; mt[0] = 0; mt[1] = 0; movf[0] = 0; movf[1] = 0;
    mph[0] = "U"; mph[1] = "U"; m_oh = 0; m_cf = 0; m_sq = 0; mcnt = 0;

    // reset
    cyc(1, LR, LR, 0, 0);
    cyc(1, LR, LR, 0, 0);
    check("rst_qa", 32'(qa), 0);
    check("rst_TA", 32'(TA), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);

    // three arrivals on red
    for (int i = 0; i < 3; i++) begin
      cyc(0, LR, LR, 1, 0);
      check("arr_qa", 32'(qa), i + 1);
      check("arr_TA", 32'(TA), 1);
    end
    check("arr_no_err", 32'(err_cnt), 0);

    // drain on green, one car per two green cycles
    for (int i = 0; i < 6; i++) begin
      cyc(0, LG, LR, 0, 0);
      check("drain_qa", 32'(qa), exp_qa[i]);
    end
    check("drain_TA", 32'(TA), 0);

    // fill to the top, then overflow
    cyc(0, LY, LR, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, LR, LR, 1, 0);
    check("full_qa", 32'(qa), 15);
    check("full_ovf", 32'(ovf_a), 0);
    cyc(0, LR, LR, 1, 0);
    check("ovf_qa", 32'(qa), 15);
    check("ovf_a", 32'(ovf_a), 1);
    for (int i = 0; i < 4; i++) cyc(0, LG, LR, 1, 0);
    check("cancel_qa", 32'(qa), 15);

    // legal cycle on A, then illegal G->R
    cyc(0, LY, LR, 0, 0);
    cyc(0, LR, LR, 0, 0);
    cyc(0, LG, LR, 0, 0);
    check("legal_seq", 32'(err_seq), 0);
    check("legal_cnt", 32'(err_cnt), 0);
    cyc(0, LR, LR, 0, 0);
    check("gr_seq", 32'(err_seq), 1);
    check("gr_cnt", 32'(err_cnt), 1);

    // conflict, one-hot, and both in one cycle
    cyc(0, LG, LG, 0, 0);
    check("cf_flag", 32'(err_conflict), 1);
    check("cf_cnt", 32'(err_cnt), 2);
    cyc(0, LRY, LY, 0, 0);
    check("oh_flag", 32'(err_onehot), 1);
    check("oh_cnt", 32'(err_cnt), 3);
    cyc(0, LYG, LY, 0, 0);
    check("both_cnt", 32'(err_cnt), 4);

    // drain A to 5, then reset mid-operation
    guard = 0;
    while (mq[0] != 5 && guard < 100) begin
      cyc(0, LG, LR, 0, 0);
      guard++;
    end
    check("pre_rst_qa", 32'(qa), 5);
    check("pre_rst_flags", 32'({err_onehot, err_conflict, err_seq, ovf_a}), 15);
    cyc(1, LG, LR, 1, 1);
    check("post_rst_q", 32'({qa, qb}), 0);
    check("post_rst_T", 32'({TA, TB}), 0);
    check("post_rst_flags", 32'({err_onehot, err_conflict, err_seq, ovf_a, ovf_b}), 0);
    check("post_rst_cnt", 32'(err_cnt), 0);
    cyc(0, LG, LR, 0, 0);
    check("unk_accept_seq", 32'(err_seq), 0);
    check("unk_accept_cnt", 32'(err_cnt), 0);
    cyc(0, LY, LR, 0, 0);

    // counter saturation
    for (int i = 0; i < 260; i++) cyc(0, LG, LG, 0, 0);
    check("sat_cnt", 32'(err_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
